m_trigger_ctrl: RTL
===================

M_TRIGGER_CTRL -- requirements
Module: m_trigger_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, capture buffer address width.
REQ-002 SHALL have parameter TMR_W, default 16, holdoff/auto-timeout counter width.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 arm  in  1  one-cycle start request.
REQ-006 stop  in  1  abort to IDLE.
REQ-007 force  in  1  software trigger.
REQ-008 ack  in  1  readout finished, releases DONE.
REQ-009 mode  in  2  0 AUTO, 1 NORMAL, 2 SINGLE, 3 treated as SINGLE.
REQ-010 edge_sel  in  1  0 uses positive, 1 uses negative.
REQ-011 positive / negative  in  1 each  transition flags from delta comparator, same cycle as sample being written.
REQ-012 pretrig / posttrig  in  ADDR_W each  sample counts before/after trigger.
REQ-013 holdoff / auto_timeout  in  TMR_W each  cycle counts.
REQ-014 wr_en  out  1  buffer write strobe; wr_addr  out  ADDR_W  buffer write address.
REQ-015 trig_addr  out  ADDR_W  address of trigger sample.
REQ-016 triggered, done, busy  out  1 each; state  out  3  current state code.

Function
REQ-017 States IDLE, PRE, WAIT, POST, DONE, HOLDOFF; all outputs registered.
REQ-018 wr_en=1 exactly in PRE, WAIT, POST; wr_addr increments after every write, wraps 2^ADDR_W-1 -> 0, never reset except by rst_n.
REQ-019 IDLE: arm -> PRE; arm in any other state ignored.
REQ-020 PRE: lasts max(pretrig,1) cycles, one write each, trigger inputs ignored, then -> WAIT.
REQ-021 WAIT: event = selected edge flag OR force OR (mode AUTO and WAIT-cycle count == auto_timeout; 0 fires first WAIT cycle); on event trig_addr <= wr_addr of that cycle, triggered <= 1, -> POST, or -> DONE if posttrig==0.
REQ-022 Simultaneous edge/force/timeout SHALL yield one trigger.
REQ-023 POST: lasts posttrig cycles, one write each, then -> DONE.
REQ-024 DONE: done=1, wr_en=0; ack -> IDLE if SINGLE, else -> HOLDOFF.
REQ-025 HOLDOFF: triggered cleared, counts holdoff cycles (0 = one cycle), then -> PRE.
REQ-026 stop in any state -> IDLE next cycle, overriding all other inputs; triggered, done cleared; wr_addr, trig_addr kept.
REQ-027 busy=1 in PRE, WAIT, POST, HOLDOFF.
REQ-028 pretrig+posttrig > 2^ADDR_W not checked; oldest samples overwritten.
REQ-029 Parameter inputs sampled continuously; changing them mid-capture affects only not-yet-completed counts.

Reset
REQ-030 rst_n low: state IDLE, wr_en 0, wr_addr 0, trig_addr 0, triggered 0, done 0, busy 0, all counters 0, asynchronously.
REQ-031 Reset deassertion mid-capture SHALL resume from IDLE only; no capture restarts without arm.

Structure
REQ-032 Package m_trigger_pkg SHALL hold state encodings (IDLE=0..HOLDOFF=5) and mode constants.
REQ-033 One sub-module m_cycle_counter (TMR_W, clear, enable, terminal-match output) SHALL serve PRE/POST sample counts and holdoff/timeout timing.

Verification
REQ-034 ADDR_W=4, pretrig 3, posttrig 4, NORMAL, edge_sel 0, arm at cycle 0, positive at cycle 6 -> writes addr 0-2 cycles 1-3, trig_addr=5, POST writes 6-9, done=1 cycle 11.
REQ-035 AUTO, auto_timeout 5, no edges -> trigger on sixth WAIT cycle, triggered=1, trig_addr = wr_addr at that cycle.
REQ-036 wr_addr at 14, pretrig 3 -> PRE writes 14,15,0; trigger next cycle gives trig_addr=1.
REQ-037 stop asserted same cycle as positive in WAIT -> no trigger, IDLE next cycle, triggered 0, wr_en 0.
REQ-038 NORMAL, holdoff 10, ack in DONE -> HOLDOFF 10 cycles with wr_en 0, then PRE; SINGLE with ack -> IDLE, busy 0.
REQ-039 rst_n low during POST -> all outputs at reset values immediately, stays IDLE until arm.

Source files
------------

// File: rtl/m_trigger_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_trigger_pkg                                                |
// | Description : Shared definitions for the capture trigger controller:       |
// |               FSM state codes (also driven on the 3-bit state port),       |
// |               acquisition mode codes and a mode decode helper.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package m_trigger_pkg;

  // State codes are visible to software through the state port, so the
  // numeric values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_e;

  localparam logic [1:0] MODE_AUTO    = 2'd0;
  localparam logic [1:0] MODE_NORMAL  = 2'd1;
  localparam logic [1:0] MODE_SINGLE  = 2'd2;
  localparam logic [1:0] MODE_SINGLE3 = 2'd3;  // reserved code, behaves as SINGLE

  // SINGLE captures return to IDLE after ack instead of re-arming.
  function automatic logic is_single(input logic [1:0] mode);
    return (mode == MODE_SINGLE) || (mode == MODE_SINGLE3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_cycle_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_cycle_counter                                              |
// | Description : Up-counter that reports when it has reached a terminal       |
// |               value. Shared by the trigger FSM for pre/post sample counts, |
// |               holdoff timing and the AUTO-mode timeout.                    |
// | Ports       : clk, rst_n  - clock, async active-low reset                  |
// |               clear       - synchronous return to zero (wins over enable)  |
// |               enable      - advance by one this cycle                      |
// |               terminal    - value at which match asserts                   |
// |               match       - count has reached (or passed) terminal         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module m_cycle_counter #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMR_W-1:0] terminal,
  output logic             match
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // Saturate instead of wrapping so a long WAIT can never alias back onto
  // a small timeout value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // ">=" rather than "==" so that lowering the terminal mid-count ends the
  // phase promptly instead of running to saturation.
  assign match = (count_q >= terminal);

endmodule
`default_nettype wire

// File: rtl/m_trigger_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_trigger_ctrl                                               |
// | Description : Capture-buffer trigger controller. Fills pre-trigger         |
// |               samples, waits for an edge / software / timeout trigger,     |
// |               records the trigger address, fills post-trigger samples,     |
// |               then waits for readout ack before holdoff or idle.           |
// | Ports       : clk, rst_n                 - clock, async active-low reset   |
// |               arm, stop, force_trig, ack - control strobes                 |
// |                 (force_trig is the software trigger; 'force' is reserved) |
// |               mode, edge_sel             - acquisition mode, edge select   |
// |               positive, negative         - edge flags of current sample    |
// |               pretrig, posttrig          - sample counts around trigger    |
// |               holdoff, auto_timeout      - cycle counts                    |
// |               wr_en, wr_addr             - capture buffer write port       |
// |               trig_addr                  - address of trigger sample       |
// |               triggered, done, busy      - status                          |
// |               state                      - current state code              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module m_trigger_ctrl
  import m_trigger_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int TMR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              stop,
  input  logic              force_trig,
  input  logic              ack,
  input  logic [1:0]        mode,
  input  logic              edge_sel,
  input  logic              positive,
  input  logic              negative,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [ADDR_W-1:0] posttrig,
  input  logic [TMR_W-1:0]  holdoff,
  input  logic [TMR_W-1:0]  auto_timeout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              triggered,
  output logic              done,
  output logic              busy,
  output logic [2:0]        state
);

  state_e            state_q,     state_d;
  logic              wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              triggered_q, triggered_d;
  logic              done_q,      done_d;
  logic              busy_q,      busy_d;

  logic [ADDR_W-1:0] pre_last;
  logic [ADDR_W-1:0] post_last;
  logic [TMR_W-1:0]  hold_last;
  logic [TMR_W-1:0]  cnt_term;
  logic              cnt_match;
  logic              cnt_clear;
  logic              trig_event;

  // Last index of each counted phase. PRE and HOLDOFF last at least one
  // cycle even when programmed to zero.
  assign pre_last  = (pretrig  == '0) ? '0 : pretrig  - ADDR_W'(1);
  assign post_last = (posttrig == '0) ? '0 : posttrig - ADDR_W'(1);
  assign hold_last = (holdoff  == '0) ? '0 : holdoff  - TMR_W'(1);

  // The counter restarts at zero on every state change, so in each phase
  // its value is the number of cycles already spent there.
  always_comb begin
    cnt_term = '0;
    case (state_q)
      ST_PRE:     cnt_term = TMR_W'(pre_last);
      ST_WAIT:    cnt_term = auto_timeout;
      ST_POST:    cnt_term = TMR_W'(post_last);
      ST_HOLDOFF: cnt_term = hold_last;
      default:    cnt_term = '0;
    endcase
  end

  assign cnt_clear = (state_d != state_q);

  m_cycle_counter #(
    .TMR_W (TMR_W)
  ) u_cycle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .enable   (busy_q),
    .terminal (cnt_term),
    .match    (cnt_match)
  );

  // Edge, software and timeout sources are OR-ed into one event, so any
  // coincidence of them produces a single trigger.
  assign trig_event = (edge_sel ? negative : positive) | force_trig |
                      ((mode == MODE_AUTO) & cnt_match);

  always_comb begin
    state_d     = state_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    // The address presented this cycle is consumed by the write in flight.
    wr_addr_d   = wr_en_q ? (wr_addr_q + ADDR_W'(1)) : wr_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d     = ST_PRE;
          triggered_d = 1'b0;
        end
      end
      ST_PRE: begin
        if (cnt_match) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (trig_event) begin
          trig_addr_d = wr_addr_q;
          triggered_d = 1'b1;
          state_d     = (posttrig == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (cnt_match) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ack) begin
          if (is_single(mode)) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_HOLDOFF;
            triggered_d = 1'b0;
          end
        end
      end
      ST_HOLDOFF: begin
        if (cnt_match) state_d = ST_PRE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a trigger in the same cycle.
    if (stop) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
      trig_addr_d = trig_addr_q;
    end

    wr_en_d = state_d inside {ST_PRE, ST_WAIT, ST_POST};
    busy_d  = state_d inside {ST_PRE, ST_WAIT, ST_POST, ST_HOLDOFF};
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign trig_addr = trig_addr_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule
`default_nettype wire
